spi_slave_core: RTL and testbench

//  MMIO-slot SPI responder (slave): the target end of the SPI master core's protocol. An external SPI

---
 rtl/spi_slave_core.sv | 157 +++++++++++++++
 tb/tb_spi_slave_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave that sits in an MMIO slot: the CPU preloads a TX byte and collects the RX byte and status flags.
// SCLK, MOSI and SS_N come from another clock domain, so they are resynchronised and edge-detected in the clk domain.
module spi_slave_core #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] DUMMY_BYTE  = '0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        miso_oe
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic sclk_d, ss_d;
    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [DATA_W-1:0] shift_reg, tx_buf, rx_data, load_val;
    logic [CNT_W-1:0]  bit_cnt;
    logic              miso_q, tx_empty, rx_valid, overrun, abort;
    logic              load_en, shift_en, frame_done, abort_set, miso_fall, frame_end;
    logic              wr_tx, wr_clr;

    // Synchronisers idle at sclk low / ss_n high so a reset never looks like a frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    assign load_val   = tx_empty ? DUMMY_BYTE : tx_buf;
    assign load_en    = (state == LOAD);
    assign frame_end  = (state == SHIFT) && ss_rise;
    assign shift_en   = (state == SHIFT) && !ss_rise && sclk_rise;
    assign frame_done = shift_en && (bit_cnt == LAST_BIT);
    assign abort_set  = frame_end && (bit_cnt != '0);
    assign miso_fall  = (state == SHIFT) && !ss_rise && sclk_fall;
    assign wr_tx      = cs && write && (addr[1:0] == 2'd0);
    assign wr_clr     = cs && write && (addr[1:0] == 2'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A finished frame goes straight back to LOAD so back-to-back bytes need no gap
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall) state_next = LOAD;
            LOAD:    state_next = ss_rise ? IDLE : SHIFT;
            SHIFT: begin
                if (ss_rise)         state_next = IDLE;
                else if (frame_done) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            miso_q    <= 1'b0;
            rx_data   <= '0;
        end else begin
            if (load_en) begin
                shift_reg <= load_val;
                bit_cnt   <= '0;
                miso_q    <= load_val[DATA_W-1];
            end else if (frame_end) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[DATA_W-2:0], mosi_s};
                bit_cnt   <= frame_done ? '0 : bit_cnt + 1'b1;
            end else if (miso_fall) begin
                miso_q <= shift_reg[DATA_W-1];
            end
            if (frame_done) rx_data <= {shift_reg[DATA_W-2:0], mosi_s};
        end
    end

    // CPU writes beat the engine on tx_empty; engine set events beat CPU clears on the flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_buf   <= '0;
            tx_empty <= 1'b1;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            abort    <= 1'b0;
        end else begin
            if (wr_tx) begin
                tx_buf   <= wr_data[DATA_W-1:0];
                tx_empty <= 1'b0;
            end else if (load_en) begin
                tx_empty <= 1'b1;
            end
            if (frame_done)             rx_valid <= 1'b1;
            else if (wr_clr && wr_data[0]) rx_valid <= 1'b0;
            if (frame_done && rx_valid) overrun <= 1'b1;
            else if (wr_clr && wr_data[2]) overrun <= 1'b0;
            if (abort_set)              abort <= 1'b1;
            else if (wr_clr && wr_data[4]) abort <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr[1:0])
            2'd0:    rd_data = 32'(rx_data);
            2'd1:    rd_data = {27'b0, abort, (state != IDLE), overrun, tx_empty, rx_valid};
            default: rd_data = '0;
        endcase
    end

    assign miso_oe  = ~ss_s;
    assign spi_miso = miso_q & miso_oe;

    logic unused_ok;
    assign unused_ok = ^{read, addr[4:2], wr_data[31:DATA_W]};

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: the bench plays the SPI master at clk/10 and the CPU on the MMIO slot.
module tb_spi_slave_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0, write = 1'b0, read = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        spi_sclk = 1'b0, spi_mosi = 1'b0, spi_ss_n = 1'b1;
    logic        spi_miso, miso_oe;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_val;
    logic [7:0]  miso_byte;

    spi_slave_core dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .read(read),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .spi_miso(spi_miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpuWrite(input logic [4:0] a, input logic [31:0] d, input logic sel);
        @(negedge clk);
        cs = sel; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic cpuRead(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; addr = a;
        #1 d = rd_data;
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
    endtask

    // Master side of mode 0: MOSI set while SCLK low, MISO sampled just before each rising edge
    task automatic applyStimulus(input logic [7:0] mosi_byte, input int nbits, output logic [7:0] miso_out);
        miso_out = '0;
        if (spi_ss_n) begin
            spi_ss_n = 1'b0;
            waitClocks(10);
        end
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mosi_byte[7-i];
            waitClocks(5);
            miso_out[7-i] = spi_miso;
            spi_sclk = 1'b1;
            waitClocks(5);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic endFrame();
        waitClocks(5);
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        waitClocks(10);
    endtask

    initial begin
        // reset state
        waitClocks(3);
        addr = 5'd1;
        #1;
        checkOutput("reset_status", rd_data, 32'h02);
        checkOutput("reset_miso_oe", {31'b0, miso_oe}, 32'h0);
        checkOutput("reset_miso", {31'b0, spi_miso}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        waitClocks(3);

        // writes without cs must not touch the TX buffer
        cpuWrite(5'd0, 32'h99, 1'b0);
        cpuRead(5'd1, rd_val);
        checkOutput("cs0_write_ignored", rd_val, 32'h02);

        // preloaded TX byte, master sends 0x3C
        cpuWrite(5'd0, 32'hA5, 1'b1);
        cpuRead(5'd1, rd_val);
        checkOutput("tx_loaded_status", rd_val, 32'h00);
        applyStimulus(8'h3C, 8, miso_byte);
        checkOutput("t2_miso", {24'b0, miso_byte}, 32'hA5);
        waitClocks(4);
        cpuRead(5'd0, rd_val);
        checkOutput("t2_rx_data", rd_val, 32'h3C);
        cpuRead(5'd1, rd_val);
        checkOutput("t2_status_ss_low", rd_val, 32'h0B);
        endFrame();
        cpuRead(5'd1, rd_val);
        checkOutput("t2_status_ss_high", rd_val, 32'h03);
        cpuRead(5'd2, rd_val);
        checkOutput("addr2_reads_zero", rd_val, 32'h0);
        cpuWrite(5'd2, 32'h15, 1'b1);
        cpuRead(5'd1, rd_val);
        checkOutput("t2_cleared", rd_val, 32'h02);

        // empty TX buffer shifts out the dummy byte
        applyStimulus(8'h81, 8, miso_byte);
        endFrame();
        checkOutput("t3_miso_dummy", {24'b0, miso_byte}, 32'h00);
        cpuRead(5'd0, rd_val);
        checkOutput("t3_rx_data", rd_val, 32'h81);
        cpuWrite(5'd2, 32'h01, 1'b1);

        // back-to-back frames without servicing rx_valid
        applyStimulus(8'h11, 8, miso_byte);
        applyStimulus(8'h22, 8, miso_byte);
        endFrame();
        cpuRead(5'd0, rd_val);
        checkOutput("t4_rx_data", rd_val, 32'h22);
        cpuRead(5'd1, rd_val);
        checkOutput("t4_overrun_status", rd_val, 32'h07);
        cpuWrite(5'd2, 32'h05, 1'b1);
        cpuRead(5'd1, rd_val);
        checkOutput("t4_after_clear", rd_val, 32'h02);

        // partial frame aborted after 5 bits
        applyStimulus(8'hF0, 5, miso_byte);
        endFrame();
        cpuRead(5'd1, rd_val);
        checkOutput("t5_abort_status", rd_val, 32'h12);
        cpuRead(5'd0, rd_val);
        checkOutput("t5_rx_unchanged", rd_val, 32'h22);
        cpuWrite(5'd2, 32'h10, 1'b1);
        applyStimulus(8'h7E, 8, miso_byte);
        endFrame();
        cpuRead(5'd0, rd_val);
        checkOutput("t5_rx_next", rd_val, 32'h7E);
        cpuRead(5'd1, rd_val);
        checkOutput("t5_status_next", rd_val, 32'h03);

        // reset pulsed mid-frame
        applyStimulus(8'hC3, 3, miso_byte);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_miso_oe", {31'b0, miso_oe}, 32'h0);
        checkOutput("t6_miso", {31'b0, spi_miso}, 32'h0);
        addr = 5'd1;
        #1;
        checkOutput("t6_status", rd_data, 32'h02);
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        waitClocks(2);
        reset_n = 1'b1;
        waitClocks(10);
        cpuRead(5'd0, rd_val);
        checkOutput("t6_rx_cleared", rd_val, 32'h00);
        cpuWrite(5'd0, 32'h5A, 1'b1);
        applyStimulus(8'hC3, 8, miso_byte);
        endFrame();
        checkOutput("t6_miso", {24'b0, miso_byte}, 32'h5A);
        cpuRead(5'd0, rd_val);
        checkOutput("t6_rx_data", rd_val, 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
